keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 194 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scan, row debounce and key-event pulses.
// Optional build macro KEYPAD_MULTI_REJECT_EN: treat multi-key scans as a distinct, rejected result.
module keypad_scanner #(
    parameter int SCAN_CYCLES    = 8,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] digit,
    output logic       valid,
    output logic       relock,
    output logic       key_event,
    output logic       key_held
);

    localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int NW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [NW-1:0] CNT_ONE  = NW'(1);
    localparam logic [NW-1:0] CNT_LAST = NW'(DEBOUNCE_SCANS);

    // Key code per image bit, image index = column*4 + row
    localparam logic [63:0] KEY_MAP = {
        4'd13, 4'd12, 4'd11, 4'd10,
        4'd15, 4'd9,  4'd6,  4'd3,
        4'd0,  4'd8,  4'd5,  4'd2,
        4'd14, 4'd7,  4'd4,  4'd1
    };

    typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_t;
    typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;

    logic [3:0]    sync1_q, sync2_q;
    logic [CW-1:0] cyc_q;
    logic [1:0]    col_q;
    logic [3:0]    col_n_q;
    logic [11:0]   img_q;

    state_t        state_q;
    logic [NW-1:0] cnt_q;
    logic [3:0]    cand_q;
    logic [3:0]    digit_q;
    logic          valid_q, relock_q, event_q, held_q;

    logic          col_last, scan_done, accept;
    logic [15:0]   img;
    logic [4:0]    n_hit;
    logic [3:0]    res_code;
    res_t          res;

    assign col_last  = (cyc_q == CYC_LAST);
    assign scan_done = col_last && (col_q == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            cyc_q   <= '0;
            col_q   <= '0;
            col_n_q <= 4'b1110;
            img_q   <= '0;
        end else begin
            sync1_q <= row_n;
            sync2_q <= sync1_q;
            if (col_last) begin
                cyc_q   <= '0;
                col_q   <= col_q + 2'd1;
                col_n_q <= {col_n_q[2:0], col_n_q[3]};
                case (col_q)
                    2'd0:    img_q[3:0]  <= ~sync2_q;
                    2'd1:    img_q[7:4]  <= ~sync2_q;
                    2'd2:    img_q[11:8] <= ~sync2_q;
                    default: ;
                endcase
            end else begin
                cyc_q <= cyc_q + CW'(1);
            end
        end
    end

    // Column 3 is taken straight from the synchroniser on the scan_done cycle
    always_comb begin
        img      = {~sync2_q, img_q};
        n_hit    = '0;
        res_code = '0;
        for (int i = 15; i >= 0; i--) begin
            if (img[i]) begin
                n_hit    = n_hit + 5'd1;
                res_code = KEY_MAP[i*4 +: 4];
            end
        end
        if (n_hit == 5'd0) begin
            res = RES_NONE;
        end else if (n_hit == 5'd1) begin
            res = RES_SINGLE;
        end else begin
`ifdef KEYPAD_MULTI_REJECT_EN
            res = RES_MULTI;
`else
            res = RES_SINGLE;
`endif
        end
    end

    always_comb begin
        accept = 1'b0;
        if (scan_done && res == RES_SINGLE) begin
            if (state_q == IDLE && DEBOUNCE_SCANS == 1)
                accept = 1'b1;
            else if (state_q == CAND && res_code == cand_q
                     && (cnt_q + CNT_ONE) == CNT_LAST)
                accept = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cand_q   <= '0;
            digit_q  <= '0;
            valid_q  <= 1'b0;
            relock_q <= 1'b0;
            event_q  <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            valid_q  <= 1'b0;
            relock_q <= 1'b0;
            event_q  <= 1'b0;
            if (accept) begin
                state_q  <= PRESSED;
                cnt_q    <= '0;
                held_q   <= 1'b1;
                digit_q  <= res_code;
                event_q  <= 1'b1;
                valid_q  <= (res_code <= 4'd9);
                relock_q <= (res_code == 4'd14);
            end else if (scan_done) begin
                unique case (state_q)
                    IDLE: begin
                        if (res == RES_SINGLE) begin
                            state_q <= CAND;
                            cand_q  <= res_code;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                    CAND: begin
                        if (res == RES_SINGLE && res_code == cand_q) begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    end
                    PRESSED: begin
                        if (res == RES_NONE) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                state_q <= IDLE;
                                held_q  <= 1'b0;
                                cnt_q   <= '0;
                            end else begin
                                state_q <= REL;
                                cnt_q   <= CNT_ONE;
                            end
                        end
                    end
                    REL: begin
                        if (res != RES_NONE) begin
                            state_q <= PRESSED;
                            cnt_q   <= '0;
                        end else if ((cnt_q + CNT_ONE) == CNT_LAST) begin
                            state_q <= IDLE;
                            held_q  <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign col_n     = col_n_q;
    assign digit     = digit_q;
    assign valid     = valid_q;
    assign relock    = relock_q;
    assign key_event = event_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix emulation with a scan-level reference model.
module tb_keypad_scanner;

    localparam int SC   = 4;
    localparam int DB   = 3;
    localparam int SCAN = 4 * SC;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_n, col_n, digit;
    logic       valid, relock, key_event, key_held;

    // Pressed keys, bit index = row*4 + col
    logic [15:0] keys;

    int n_vec = 0;
    int n_err = 0;
    int o_val, o_rel, o_ev;

    int m_held, m_run, m_cand, m_rel, m_digit;

    int CODE [4][4] = '{
        '{1, 2, 3, 10},
        '{4, 5, 6, 11},
        '{7, 8, 9, 12},
        '{14, 0, 15, 13}
    };

    keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .digit     (digit),
        .valid     (valid),
        .relock    (relock),
        .key_event (key_event),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key shorts its row to the driven column
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] key_at(input int r, input int c);
        logic [15:0] m;
        m = '0;
        m[r*4+c] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        m_held  = 0;
        m_run   = 0;
        m_cand  = 0;
        m_rel   = 0;
        m_digit = 0;
    endtask

    task automatic model_scan(input logic [15:0] pat, output bit ev,
                              output int code);
        int n;
        int first;
        bit multi;
        n     = 0;
        first = -1;
        ev    = 1'b0;
        code  = 0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pat[r*4+c]) begin
                    n++;
                    if (first < 0) first = CODE[r][c];
                end
`ifdef KEYPAD_MULTI_REJECT_EN
        multi = (n > 1);
`else
        multi = 1'b0;
`endif
        if (m_held != 0) begin
            if (n == 0) begin
                m_rel++;
                if (m_rel >= DB) begin
                    m_held = 0;
                    m_rel  = 0;
                end
            end else begin
                m_rel = 0;
            end
        end else if (n == 0 || multi) begin
            m_run = 0;
        end else if (m_run > 0 && first != m_cand) begin
            m_run = 0;
        end else begin
            if (m_run == 0) m_cand = first;
            m_run++;
            if (m_run >= DB) begin
                m_held  = 1;
                m_run   = 0;
                m_rel   = 0;
                ev      = 1'b1;
                code    = first;
                m_digit = first;
            end
        end
    endtask

    task automatic run_scan(input logic [15:0] pat);
        bit ev;
        int code;
        keys = pat;
        model_scan(pat, ev, code);
        for (int k = 1; k <= SCAN; k++) begin
            @(posedge clk);
            #1;
            o_val += int'(valid);
            o_rel += int'(relock);
            o_ev  += int'(key_event);
            check_val("col_n", col_n, 4'hF ^ (4'd1 << ((k % SCAN) / SC)));
            if (k < SCAN) begin
                check_val("idle_pulses", {valid, relock, key_event}, 3'b000);
            end else begin
                check_val("valid", valid, ev && code <= 9);
                check_val("relock", relock, ev && code == 14);
                check_val("key_event", key_event, ev);
                check_val("digit", digit, m_digit);
                check_val("key_held", key_held, m_held);
            end
        end
    endtask

    task automatic hold(input logic [15:0] pat, input int n);
        for (int i = 0; i < n; i++) run_scan(pat);
    endtask

    task automatic clr_obs();
        o_val = 0;
        o_rel = 0;
        o_ev  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] pat;
        rst  = 1'b1;
        keys = '0;
        clr_obs();
        model_reset();
        #1;
        check_val("rst_col_n", col_n, 4'b1110);
        check_val("rst_digit", digit, 0);
        check_val("rst_pulses", {valid, relock, key_event, key_held}, 4'b0000);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        clr_obs();
        hold(key_at(1, 1), 10);
        hold('0, 2);
        check_val("held_2_after_release", key_held, 1);
        hold('0, 1);
        check_val("held_3_after_release", key_held, 0);
        check_val("n_valid_5", o_val, 1);
        check_val("n_event_5", o_ev, 1);
        check_val("n_relock_5", o_rel, 0);
        check_val("digit_5", digit, 5);

        clr_obs();
        for (int i = 0; i < 3; i++) begin
            hold(key_at(2, 0), 2);
            hold('0, 1);
        end
        check_val("bounce_events", o_ev, 0);
        check_val("bounce_valid", o_val, 0);

        clr_obs();
        hold(key_at(3, 0), 5);
        hold('0, 4);
        check_val("star_relock", o_rel, 1);
        check_val("star_valid", o_val, 0);
        check_val("star_digit", digit, 14);
        clr_obs();
        hold(key_at(0, 3), 5);
        hold('0, 4);
        check_val("a_event", o_ev, 1);
        check_val("a_valid", o_val, 0);
        check_val("a_digit", digit, 10);

        clr_obs();
        hold(key_at(0, 0) | key_at(2, 2), 5);
        hold('0, 4);
`ifdef KEYPAD_MULTI_REJECT_EN
        check_val("multi_events", o_ev, 0);
`else
        check_val("multi_valid", o_val, 1);
        check_val("multi_digit", digit, 1);
`endif

        clr_obs();
        hold(key_at(0, 0), 5);
        hold('0, 5);
        hold(key_at(0, 1), 5);
        hold('0, 5);
        hold(key_at(0, 2), 5);
        hold('0, 5);
        hold(key_at(1, 0), 5);
        hold('0, 5);
        check_val("seq_valid", o_val, 4);
        check_val("seq_last_digit", digit, 4);

        for (int i = 0; i < 40; i++) begin
            pat = '0;
            pat[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 3) == 0) pat[$urandom_range(0, 15)] = 1'b1;
            hold(pat, $urandom_range(1, 6));
            hold('0, $urandom_range(0, 4));
        end

        hold('0, 4);
        hold(key_at(0, 2), 2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_val("midrst_col_n", col_n, 4'b1110);
        check_val("midrst_pulses", {valid, relock, key_event, key_held}, 4'b0000);
        check_val("midrst_digit", digit, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clr_obs();
        hold(key_at(0, 2), 2);
        check_val("midrst_no_early", o_ev, 0);
        hold(key_at(0, 2), 3);
        hold('0, 4);
        check_val("midrst_valid", o_val, 1);
        check_val("midrst_digit3", digit, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
